// File: rtl/vga_pkg.sv
// Shared VGA timing, coordinate and colour constants for the raster scan generator
// and the display blocks that consume its row/col -> d_out interface.
package vga_pkg;

  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP   = 48;
  localparam int VGA_H_ACT  = 640;
  localparam int VGA_H_FP   = 16;
  localparam int VGA_H_TOT  = VGA_H_SYNC + VGA_H_BP + VGA_H_ACT + VGA_H_FP;

  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP   = 33;
  localparam int VGA_V_ACT  = 480;
  localparam int VGA_V_FP   = 10;
  localparam int VGA_V_TOT  = VGA_V_SYNC + VGA_V_BP + VGA_V_ACT + VGA_V_FP;

  localparam int CNT_W = 10;
  localparam int ROW_W = 9;
  localparam int COL_W = 10;
  localparam int PIX_W = 12;
  localparam int DIV_W = 3;

  localparam logic [ROW_W-1:0] ROW_BLANK = 9'h1FF;
  localparam logic [COL_W-1:0] COL_BLANK = 10'h3FF;

  localparam logic [PIX_W-1:0] PIX_WHITE = 12'hfff;
  localparam logic [PIX_W-1:0] PIX_SKY   = 12'h048;

  function automatic int axis_total(input int sync, input int bp, input int act, input int fp);
    return sync + bp + act + fp;
  endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// One raster axis: wrapping position counter plus sync/active/offset decode of the
// position the counter is about to take, so the caller can register it on the same edge.
module vga_axis_cnt
  import vga_pkg::*;
#(
  parameter int SYNC    = VGA_H_SYNC,
  parameter int BP      = VGA_H_BP,
  parameter int ACT     = VGA_H_ACT,
  parameter int FP      = VGA_H_FP,
  parameter int COORD_W = COL_W
) (
  input  logic               Clk,
  input  logic               rst,
  input  logic               en,
  output logic               wrap,
  output logic [CNT_W-1:0]   count,
  output logic               sync_n,
  output logic               active,
  output logic [COORD_W-1:0] coord
);

  localparam int TOT = axis_total(SYNC, BP, ACT, FP);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOT - 1);
  localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(SYNC);
  localparam logic [CNT_W-1:0] ACT_LO   = CNT_W'(SYNC + BP);
  localparam logic [CNT_W-1:0] ACT_HI   = CNT_W'(SYNC + BP + ACT);

  logic [CNT_W-1:0] count_nxt;

  // >= rather than == so a corrupted count can never run past the line/frame end
  assign wrap = en && (count >= LAST);

  always_comb begin
    count_nxt = count;
    if (en) begin
      count_nxt = (count >= LAST) ? '0 : count + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

  assign sync_n = (count_nxt >= SYNC_END);
  assign active = (count_nxt >= ACT_LO) && (count_nxt < ACT_HI);
  assign coord  = COORD_W'(count_nxt - ACT_LO);

endmodule

// File: rtl/vga_scan.sv
// 640x480@60 raster scan generator: pixel-rate divider, row/col address issue,
// and registered RGB/sync outputs aligned one pixel behind the issued address.
module vga_scan
  import vga_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int H_SYNC  = VGA_H_SYNC,
  parameter int H_BP    = VGA_H_BP,
  parameter int H_ACT   = VGA_H_ACT,
  parameter int H_FP    = VGA_H_FP,
  parameter int V_SYNC  = VGA_V_SYNC,
  parameter int V_BP    = VGA_V_BP,
  parameter int V_ACT   = VGA_V_ACT,
  parameter int V_FP    = VGA_V_FP
) (
  input  logic             Clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] d_in,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             rdn,
  output logic             hs,
  output logic             vs,
  output logic [3:0]       r,
  output logic [3:0]       g,
  output logic [3:0]       b,
  output logic             frame_tick
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(axis_total(H_SYNC, H_BP, H_ACT, H_FP) - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(axis_total(V_SYNC, V_BP, V_ACT, V_FP) - 1);

  function automatic logic [PIX_W-1:0] blank_gate(input logic blank, input logic [PIX_W-1:0] pix);
    return blank ? '0 : pix;
  endfunction

  logic [DIV_W-1:0] div_p0;
  logic             pix_tick;
  logic             h_wrap, v_wrap;
  logic [CNT_W-1:0] hcnt, vcnt;
  logic             h_sync_n, v_sync_n;
  logic             h_act, v_act;
  logic [COL_W-1:0] h_coord;
  logic [ROW_W-1:0] v_coord;
  logic             frame_end;
  logic             rdn_p1, hs_p1, vs_p1;

  assign pix_tick = (div_p0 == DIV_LAST);

  // Stage p0: pixel-rate divider and raster position
  always_ff @(posedge Clk) begin
    if (rst) begin
      div_p0 <= '0;
    end else begin
      div_p0 <= pix_tick ? '0 : div_p0 + DIV_W'(1);
    end
  end

  vga_axis_cnt #(
    .SYNC(H_SYNC), .BP(H_BP), .ACT(H_ACT), .FP(H_FP), .COORD_W(COL_W)
  ) u_h_axis (
    .Clk    (Clk),
    .rst    (rst),
    .en     (pix_tick),
    .wrap   (h_wrap),
    .count  (hcnt),
    .sync_n (h_sync_n),
    .active (h_act),
    .coord  (h_coord)
  );

  vga_axis_cnt #(
    .SYNC(V_SYNC), .BP(V_BP), .ACT(V_ACT), .FP(V_FP), .COORD_W(ROW_W)
  ) u_v_axis (
    .Clk    (Clk),
    .rst    (rst),
    .en     (h_wrap),
    .wrap   (v_wrap),
    .count  (vcnt),
    .sync_n (v_sync_n),
    .active (v_act),
    .coord  (v_coord)
  );

  assign frame_end = v_wrap && (hcnt == H_LAST) && (vcnt == V_LAST);

  // Stage p1: address issue and decode of the pixel being entered.
  // Sync decode resets low to match position 0,0 so the first line gets a full-width pulse.
  always_ff @(posedge Clk) begin
    if (rst) begin
      row    <= ROW_BLANK;
      col    <= COL_BLANK;
      rdn_p1 <= 1'b1;
      hs_p1  <= 1'b0;
      vs_p1  <= 1'b0;
    end else if (pix_tick) begin
      row    <= (h_act && v_act) ? v_coord : ROW_BLANK;
      col    <= (h_act && v_act) ? h_coord : COL_BLANK;
      rdn_p1 <= ~(h_act && v_act);
      hs_p1  <= h_sync_n;
      vs_p1  <= v_sync_n;
    end
  end

  // Stage p2: pixel ends; capture display data and delay sync to stay aligned
  always_ff @(posedge Clk) begin
    if (rst) begin
      rdn       <= 1'b1;
      hs        <= 1'b1;
      vs        <= 1'b1;
      {r, g, b} <= '0;
    end else if (pix_tick) begin
      rdn       <= rdn_p1;
      hs        <= hs_p1;
      vs        <= vs_p1;
      {r, g, b} <= blank_gate(rdn_p1, d_in);
    end
  end

  always_ff @(posedge Clk) begin
    if (rst) begin
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_end;
    end
  end

endmodule

// File: tb/tb_vga_scan.sv
// Bench for vga_scan: full-timing instance over the first lines and a mid-line reset,
// plus a reduced-timing instance run over whole frames with random resets.
module tb_vga_scan;
  import vga_pkg::*;

  localparam int A_DIV = 4;
  localparam int B_DIV = 2;
  localparam int BHS = 8, BHB = 4, BHA = 20, BHF = 4;
  localparam int BVS = 2, BVB = 3, BVA = 10, BVF = 2;
  localparam int B_FRAME_CLK = B_DIV * (BHS + BHB + BHA + BHF) * (BVS + BVB + BVA + BVF);

  typedef struct packed {
    logic [8:0] row;
    logic [9:0] col;
    logic       rdn;
    logic       hs;
    logic       vs;
    logic       ft;
    logic       act_prev;
    logic [8:0] prow;
    logic [9:0] pcol;
  } exp_t;

  logic       Clk = 1'b0;
  logic       rst_a, rst_b;
  logic [11:0] d_in_a, d_in_b;
  logic [8:0] row_a, row_b;
  logic [9:0] col_a, col_b;
  logic       rdn_a, rdn_b, hs_a, hs_b, vs_a, vs_b, frame_tick_a, frame_tick_b;
  logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b;

  int checks = 0;
  int errors = 0;

  longint e_a = 0, e_b = 0;
  logic [11:0] cap_a = '0;
  logic   hs_prev_a = 1'b1, vs_prev_a = 1'b1;
  longint hs_fall_a = -1, vs_fall_a = -1;
  longint ft_last_b = 0;
  int     act_cnt_b = 0;

  always #5 Clk = ~Clk;

  vga_scan #(.CLK_DIV(A_DIV)) u_dut_a (
    .Clk(Clk), .rst(rst_a), .d_in(d_in_a), .row(row_a), .col(col_a), .rdn(rdn_a),
    .hs(hs_a), .vs(vs_a), .r(r_a), .g(g_a), .b(b_a), .frame_tick(frame_tick_a)
  );

  vga_scan #(
    .CLK_DIV(B_DIV), .H_SYNC(BHS), .H_BP(BHB), .H_ACT(BHA), .H_FP(BHF),
    .V_SYNC(BVS), .V_BP(BVB), .V_ACT(BVA), .V_FP(BVF)
  ) u_dut_b (
    .Clk(Clk), .rst(rst_b), .d_in(d_in_b), .row(row_b), .col(col_b), .rdn(rdn_b),
    .hs(hs_b), .vs(vs_b), .r(r_b), .g(g_b), .b(b_b), .frame_tick(frame_tick_b)
  );

  // Clock edges since the last edge that saw reset, and the d_in seen on pixel-end edges
  always @(posedge Clk) begin
    if (rst_a) begin
      e_a <= 0;
    end else begin
      e_a <= e_a + 1;
      if ((e_a + 1) % A_DIV == 0) cap_a <= d_in_a;
    end
    if (rst_b) e_b <= 0;
    else       e_b <= e_b + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected outputs after e edges, from the pixel index e/cd along the raster
  function automatic exp_t model(input longint e, input int cd,
                                 input int hsw, input int hbp, input int hac, input int hfp,
                                 input int vsw, input int vbp, input int vac, input int vfp);
    exp_t m;
    int ht, vt, ft, p, q, h, v;
    longint n;
    ht = hsw + hbp + hac + hfp;
    vt = vsw + vbp + vac + vfp;
    ft = ht * vt;
    n  = e / cd;
    p  = int'(n % ft);
    h  = p % ht;
    v  = p / ht;
    m  = '0;
    m.row = 9'h1FF;
    m.col = 10'h3FF;
    if (h >= hsw + hbp && h < hsw + hbp + hac && v >= vsw + vbp && v < vsw + vbp + vac) begin
      m.row = 9'(v - vsw - vbp);
      m.col = 10'(h - hsw - hbp);
    end
    m.ft = (n > 0) && (e % cd == 0) && (p == 0);
    if (n == 0) begin
      m.rdn = 1'b1; m.hs = 1'b1; m.vs = 1'b1; m.act_prev = 1'b0;
    end else begin
      q = int'((n - 1) % ft);
      h = q % ht;
      v = q / ht;
      m.hs = (h >= hsw);
      m.vs = (v >= vsw);
      m.act_prev = (h >= hsw + hbp && h < hsw + hbp + hac && v >= vsw + vbp && v < vsw + vbp + vac);
      m.rdn  = !m.act_prev;
      m.prow = 9'(v - vsw - vbp);
      m.pcol = 10'(h - hsw - hbp);
    end
    return m;
  endfunction

  task automatic mon_a();
    exp_t m;
    m = model(e_a, A_DIV, VGA_H_SYNC, VGA_H_BP, VGA_H_ACT, VGA_H_FP,
              VGA_V_SYNC, VGA_V_BP, VGA_V_ACT, VGA_V_FP);
    check("a_row", 32'(row_a), 32'(m.row));
    check("a_col", 32'(col_a), 32'(m.col));
    check("a_rdn", 32'(rdn_a), 32'(m.rdn));
    check("a_hs", 32'(hs_a), 32'(m.hs));
    check("a_vs", 32'(vs_a), 32'(m.vs));
    check("a_ft", 32'(frame_tick_a), 32'(m.ft));
    check("a_rgb", 32'({r_a, g_a, b_a}), 32'(m.act_prev ? cap_a : 12'h000));
    if (e_a == 0) begin
      hs_fall_a = -1;
      vs_fall_a = -1;
    end else begin
      if (hs_prev_a && !hs_a) begin
        if (hs_fall_a >= 0) check("a_hs_period", 32'(e_a - hs_fall_a), 32'(A_DIV * VGA_H_TOT));
        hs_fall_a = e_a;
      end
      if (!hs_prev_a && hs_a && hs_fall_a >= 0)
        check("a_hs_low", 32'(e_a - hs_fall_a), 32'(A_DIV * VGA_H_SYNC));
      if (vs_prev_a && !vs_a) vs_fall_a = e_a;
      if (!vs_prev_a && vs_a && vs_fall_a >= 0)
        check("a_vs_low", 32'(e_a - vs_fall_a), 32'(A_DIV * VGA_H_TOT * VGA_V_SYNC));
    end
    hs_prev_a = hs_a;
    vs_prev_a = vs_a;
  endtask

  task automatic mon_b();
    exp_t m;
    m = model(e_b, B_DIV, BHS, BHB, BHA, BHF, BVS, BVB, BVA, BVF);
    check("b_row", 32'(row_b), 32'(m.row));
    check("b_col", 32'(col_b), 32'(m.col));
    check("b_rdn", 32'(rdn_b), 32'(m.rdn));
    check("b_hs", 32'(hs_b), 32'(m.hs));
    check("b_vs", 32'(vs_b), 32'(m.vs));
    check("b_ft", 32'(frame_tick_b), 32'(m.ft));
    check("b_rgb", 32'({r_b, g_b, b_b}),
          32'(m.act_prev ? {m.pcol[3:0], m.prow[3:0], 4'h5} : 12'h000));
    if (e_b == 0) begin
      ft_last_b = 0;
      act_cnt_b = 0;
    end else begin
      if (!rdn_b) act_cnt_b++;
      if (frame_tick_b) begin
        check("b_ft_gap", 32'(e_b - ft_last_b), 32'(B_FRAME_CLK));
        check("b_act_cnt", 32'(act_cnt_b), 32'(BHA * BVA * B_DIV));
        ft_last_b = e_b;
        act_cnt_b = 0;
      end
    end
  endtask

  task automatic run_a();
    rst_a = 1'b0;
    repeat (A_DIV * (VGA_H_TOT + 300)) @(negedge Clk);
    rst_a = 1'b1;
    @(negedge Clk);
    check("a_mid_rst_hs", 32'(hs_a), 32'd1);
    check("a_mid_rst_vs", 32'(vs_a), 32'd1);
    check("a_mid_rst_rdn", 32'(rdn_a), 32'd1);
    check("a_mid_rst_rgb", 32'({r_a, g_a, b_a}), 32'd0);
    check("a_mid_rst_col", 32'(col_a), 32'h3FF);
    @(negedge Clk);
    rst_a = 1'b0;
    repeat (A_DIV * VGA_H_TOT * 2 + 1000) @(negedge Clk);
  endtask

  task automatic run_b();
    rst_b = 1'b0;
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(2600, 900)) @(negedge Clk);
      rst_b = 1'b1;
      repeat ($urandom_range(3, 1)) @(negedge Clk);
      rst_b = 1'b0;
    end
    repeat (3 * B_FRAME_CLK + 50) @(negedge Clk);
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    d_in_a = '0;
    d_in_b = '0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst_row", 32'(row_a), 32'h1FF);
    check("rst_col", 32'(col_a), 32'h3FF);
    check("rst_rdn", 32'(rdn_a), 32'd1);
    check("rst_hs", 32'(hs_a), 32'd1);
    check("rst_vs", 32'(vs_a), 32'd1);
    check("rst_rgb", 32'({r_a, g_a, b_a}), 32'd0);
    check("rst_ft", 32'(frame_tick_a), 32'd0);
    fork
      forever begin
        @(negedge Clk);
        mon_a();
        mon_b();
        d_in_a = 12'($urandom);
        d_in_b = {col_b[3:0], row_b[3:0], 4'h5};
      end
    join_none
    fork
      run_a();
      run_b();
    join
    @(negedge Clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
